// File: rtl/boost_seq_ptr_file_pkg.sv
// rtl/boost_seq_ptr_file_pkg.sv - shared constants for the boosting sequential-pointer store
package boost_seq_ptr_file_pkg;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;

  // Write-port flag vector layout: {boost, valid}
  localparam int VALID_BIT = 0;
  localparam int BOOST_BIT = 1;

  // Commit history: bit 0 = commit last cycle, bit 1 = commit two cycles ago
  localparam int HIST_LAST_BIT = 0;
  localparam int HIST_PREV_BIT = 1;

  typedef enum logic [1:0] {
    HIST_NONE = 2'b00,
    HIST_LAST = 2'b01,
    HIST_PREV = 2'b10,
    HIST_BOTH = 2'b11
  } commitHistE;

endpackage

// File: rtl/boost_seq_ptr_file_flip_hist.sv
// rtl/boost_seq_ptr_file_flip_hist.sv - two-deep commit history and rollback mask
module boost_flip_hist
  import boost_seq_ptr_file_pkg::*;
#(
  parameter int NREGS = NUM_REGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmtEff,
  input  logic             exception,
  input  logic             stall,
  input  logic [NREGS-1:0] boostValid,
  output logic [1:0]       commitHist,
  output logic [NREGS-1:0] rbMask
);

  localparam logic [NREGS-1:0] REG0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] flip0;
  logic [NREGS-1:0] flip1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commitHist <= HIST_NONE;
      flip0      <= '0;
      flip1      <= '0;
    end else if (exception) begin
      commitHist <= HIST_NONE;
      flip0      <= '0;
      flip1      <= '0;
    end else if (!stall) begin
      commitHist <= {commitHist[HIST_LAST_BIT], cmtEff};
      flip1      <= flip0;
      flip0      <= cmtEff ? (boostValid & REG0_MASK) : '0;
    end
  end

  // Undo only the flips of commits still inside the two-cycle window
  assign rbMask = ((commitHist[HIST_LAST_BIT] ? flip0 : '0) ^
                   (commitHist[HIST_PREV_BIT] ? flip1 : '0)) & REG0_MASK;

endmodule

// File: rtl/boost_seq_ptr_file.sv
// rtl/boost_seq_ptr_file.sv - per-register SeqPtr/BoostValid store with commit, squash and rollback
module boost_seq_ptr_file
  import boost_seq_ptr_file_pkg::*;
#(
  parameter int NREGS = NUM_REGS,
  parameter int IDXW  = IDX_W
) (
  input  logic            Phi1,
  input  logic            Reset_s1,
  input  logic            Stall_s1,
  input  logic            Except_s1w,
  input  logic            Commit_s1e,
  input  logic            Squash_s1e,
  input  logic            AWrValid_s1w,
  input  logic            AWrBoost_s1w,
  input  logic [IDXW-1:0] AWrIdx_s1w,
  input  logic            BWrValid_s1w,
  input  logic            BWrBoost_s1w,
  input  logic [IDXW-1:0] BWrIdx_s1w,
  input  logic [IDXW-1:0] ARdIdx_s1e,
  input  logic [IDXW-1:0] BRdIdx_s1e,
  output logic            ASeqPtr_v1e,
  output logic            BSeqPtr_v1e,
  output logic            ABoostValid_v1e,
  output logic            BBoostValid_v1e,
  output logic            BoostPending_v1e,
  output logic [1:0]      CommitHist_s1
);

  localparam logic [NREGS-1:0] REG0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] seqPtr;
  logic [NREGS-1:0] boostValid;
  logic [NREGS-1:0] boostValidNext;
  logic [NREGS-1:0] rbMask;
  logic [1:0]       aWr;
  logic [1:0]       bWr;
  logic             cmtEff;
  logic             aHit;
  logic             bHit;

  assign aWr[VALID_BIT] = AWrValid_s1w;
  assign aWr[BOOST_BIT] = AWrBoost_s1w;
  assign bWr[VALID_BIT] = BWrValid_s1w;
  assign bWr[BOOST_BIT] = BWrBoost_s1w;

  assign cmtEff = Commit_s1e & ~Squash_s1e & ~Stall_s1 & ~Except_s1w;
  assign aHit   = aWr[VALID_BIT] && (AWrIdx_s1w != '0);
  assign bHit   = bWr[VALID_BIT] && (BWrIdx_s1w != '0);

  boost_flip_hist #(
    .NREGS(NREGS)
  ) uFlipHist (
    .clk       (Phi1),
    .rst       (Reset_s1),
    .cmtEff    (cmtEff),
    .exception (Except_s1w),
    .stall     (Stall_s1),
    .boostValid(boostValid),
    .commitHist(CommitHist_s1),
    .rbMask    (rbMask)
  );

  // Branch-window close happens first so same-cycle boosted writes open the next window
  always_comb begin
    boostValidNext = boostValid;
    if (cmtEff || (Squash_s1e && !Stall_s1)) begin
      boostValidNext = '0;
    end
    if (aHit && aWr[BOOST_BIT]) begin
      boostValidNext[AWrIdx_s1w] = 1'b1;
    end
    if (bHit) begin
      if (aHit && (AWrIdx_s1w == BWrIdx_s1w)) begin
        boostValidNext[BWrIdx_s1w] = bWr[BOOST_BIT];
      end else if (bWr[BOOST_BIT]) begin
        boostValidNext[BWrIdx_s1w] = 1'b1;
      end
    end
  end

  always_ff @(posedge Phi1 or posedge Reset_s1) begin
    if (Reset_s1) begin
      seqPtr     <= '0;
      boostValid <= '0;
    end else if (Except_s1w) begin
      seqPtr     <= seqPtr ^ rbMask;
      boostValid <= '0;
    end else begin
      boostValid <= boostValidNext;
      if (cmtEff) begin
        seqPtr <= seqPtr ^ (boostValid & REG0_MASK);
      end
    end
  end

  assign ASeqPtr_v1e      = (ARdIdx_s1e != '0) & seqPtr[ARdIdx_s1e];
  assign BSeqPtr_v1e      = (BRdIdx_s1e != '0) & seqPtr[BRdIdx_s1e];
  assign ABoostValid_v1e  = (ARdIdx_s1e != '0) & boostValid[ARdIdx_s1e];
  assign BBoostValid_v1e  = (BRdIdx_s1e != '0) & boostValid[BRdIdx_s1e];
  assign BoostPending_v1e = |boostValid;

endmodule

// File: tb/tb_boost_seq_ptr_file.sv
// tb/tb_boost_seq_ptr_file.sv - scoreboard bench for boost_seq_ptr_file
module tb_boost_seq_ptr_file;

  logic       Phi1 = 1'b0;
  logic       Reset_s1, Stall_s1, Except_s1w, Commit_s1e, Squash_s1e;
  logic       AWrValid_s1w, AWrBoost_s1w, BWrValid_s1w, BWrBoost_s1w;
  logic [4:0] AWrIdx_s1w, BWrIdx_s1w, ARdIdx_s1e, BRdIdx_s1e;
  logic       ASeqPtr_v1e, BSeqPtr_v1e, ABoostValid_v1e, BBoostValid_v1e, BoostPending_v1e;
  logic [1:0] CommitHist_s1;

  always #5 Phi1 = ~Phi1;

  boost_seq_ptr_file dut (
    .Phi1(Phi1), .Reset_s1(Reset_s1), .Stall_s1(Stall_s1), .Except_s1w(Except_s1w),
    .Commit_s1e(Commit_s1e), .Squash_s1e(Squash_s1e),
    .AWrValid_s1w(AWrValid_s1w), .AWrBoost_s1w(AWrBoost_s1w), .AWrIdx_s1w(AWrIdx_s1w),
    .BWrValid_s1w(BWrValid_s1w), .BWrBoost_s1w(BWrBoost_s1w), .BWrIdx_s1w(BWrIdx_s1w),
    .ARdIdx_s1e(ARdIdx_s1e), .BRdIdx_s1e(BRdIdx_s1e),
    .ASeqPtr_v1e(ASeqPtr_v1e), .BSeqPtr_v1e(BSeqPtr_v1e),
    .ABoostValid_v1e(ABoostValid_v1e), .BBoostValid_v1e(BBoostValid_v1e),
    .BoostPending_v1e(BoostPending_v1e), .CommitHist_s1(CommitHist_s1)
  );

  typedef struct {
    logic [6:0] outs;   // {aSeq, bSeq, aBv, bBv, pending, hist[1:0]}
    int         tag;
  } expT;

  expT expQ[$];
  int  errors = 0;
  int  checks = 0;

  // Reference model: plain per-register bit arrays plus the last two commits' flip sets
  bit        mSeq[32];
  bit        mBv[32];
  bit        hCmt[2];
  bit        hFlip[2][32];

  bit sRst, sStall, sExc, sCmt, sSq, sAv, sAb, sBv, sBb;
  int sAi, sBi, sAr, sBr;

  function automatic void modelReset();
    for (int r = 0; r < 32; r++) begin
      mSeq[r] = 0; mBv[r] = 0; hFlip[0][r] = 0; hFlip[1][r] = 0;
    end
    hCmt[0] = 0; hCmt[1] = 0;
  endfunction

  function automatic void modelEdge();
    bit cmt;
    bit fl[32];
    cmt = sCmt && !sSq && !sStall && !sExc;
    if (sExc) begin
      for (int r = 1; r < 32; r++) begin
        if (hCmt[0] && hFlip[0][r]) mSeq[r] = !mSeq[r];
        if (hCmt[1] && hFlip[1][r]) mSeq[r] = !mSeq[r];
      end
      modelResetHistAndBoost();
      return;
    end
    for (int r = 0; r < 32; r++) fl[r] = 0;
    if (!sStall) begin
      if (sSq) begin
        for (int r = 0; r < 32; r++) mBv[r] = 0;
      end else if (cmt) begin
        for (int r = 1; r < 32; r++) begin
          fl[r] = mBv[r];
          if (mBv[r]) mSeq[r] = !mSeq[r];
          mBv[r] = 0;
        end
      end
      hCmt[1] = hCmt[0];
      hCmt[0] = cmt;
      for (int r = 0; r < 32; r++) begin
        hFlip[1][r] = hFlip[0][r];
        hFlip[0][r] = fl[r];
      end
    end
    if (sAv && sAi != 0 && sAb) mBv[sAi] = 1;
    if (sBv && sBi != 0) begin
      if (sAv && sAi == sBi) mBv[sBi] = sBb;
      else if (sBb) mBv[sBi] = 1;
    end
  endfunction

  function automatic void modelResetHistAndBoost();
    for (int r = 0; r < 32; r++) begin
      mBv[r] = 0; hFlip[0][r] = 0; hFlip[1][r] = 0;
    end
    hCmt[0] = 0; hCmt[1] = 0;
  endfunction

  function automatic expT expected(input int tag);
    expT e;
    bit  pend;
    pend = 0;
    for (int r = 0; r < 32; r++) pend = pend | mBv[r];
    e.outs = {mSeq[sAr], mSeq[sBr], mBv[sAr], mBv[sBr], pend, hCmt[1], hCmt[0]};
    e.tag  = tag;
    return e;
  endfunction

  task automatic clr();
    sRst = 0; sStall = 0; sExc = 0; sCmt = 0; sSq = 0;
    sAv = 0; sAb = 0; sBv = 0; sBb = 0;
    sAi = 0; sBi = 0; sAr = 0; sBr = 0;
  endtask

  task automatic step(input int tag);
    @(negedge Phi1);
    Reset_s1 = sRst; Stall_s1 = sStall; Except_s1w = sExc;
    Commit_s1e = sCmt; Squash_s1e = sSq;
    AWrValid_s1w = sAv; AWrBoost_s1w = sAb; AWrIdx_s1w = sAi[4:0];
    BWrValid_s1w = sBv; BWrBoost_s1w = sBb; BWrIdx_s1w = sBi[4:0];
    ARdIdx_s1e = sAr[4:0]; BRdIdx_s1e = sBr[4:0];
    if (sRst) modelReset();
    expQ.push_back(expected(tag));
    @(posedge Phi1);
    if (!sRst) modelEdge();
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-low-phase
  initial begin
    expT e;
    logic [6:0] got;
    forever begin
      @(negedge Phi1);
      #2;
      if (expQ.size() > 0) begin
        e   = expQ.pop_front();
        got = {ASeqPtr_v1e, BSeqPtr_v1e, ABoostValid_v1e, BBoostValid_v1e,
               BoostPending_v1e, CommitHist_s1};
        checks++;
        if (got !== e.outs) begin
          errors++;
          $display("FAIL outs tag=%0d got=%b exp=%b (aSeq bSeq aBv bBv pend hist)",
                   e.tag, got, e.outs);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_s1 = 1; Stall_s1 = 0; Except_s1w = 0; Commit_s1e = 0; Squash_s1e = 0;
    AWrValid_s1w = 0; AWrBoost_s1w = 0; AWrIdx_s1w = 0;
    BWrValid_s1w = 0; BWrBoost_s1w = 0; BWrIdx_s1w = 0;
    ARdIdx_s1e = 0; BRdIdx_s1e = 0;
    modelReset();

    // 1: boosted write 5, commit
    clr(); sRst = 1; sAr = 5; sBr = 0; step(100);
    clr(); sAv = 1; sAb = 1; sAi = 5; sAr = 5; step(101);
    clr(); sCmt = 1; sAr = 5; sBr = 5; step(102);
    clr(); sAr = 5; sBr = 0; step(103);

    // 2: boosted writes 3 and 7, squash
    clr(); sAv = 1; sAb = 1; sAi = 3; sBv = 1; sBb = 1; sBi = 7; step(200);
    clr(); sSq = 1; sCmt = 1; sAr = 3; sBr = 7; step(201);
    clr(); sAr = 3; sBr = 7; step(202);

    // 3: boosted write 9, commit, exception
    clr(); sAv = 1; sAb = 1; sAi = 9; sAr = 9; step(300);
    clr(); sCmt = 1; sAr = 9; step(301);
    clr(); sExc = 1; sAr = 9; step(302);
    clr(); sAr = 9; step(303);

    // 4: back-to-back commits of 4 then 6, exception
    clr(); sAv = 1; sAb = 1; sAi = 4; step(400);
    clr(); sCmt = 1; sBv = 1; sBb = 1; sBi = 6; sAr = 4; sBr = 6; step(401);
    clr(); sCmt = 1; sAr = 4; sBr = 6; step(402);
    clr(); sExc = 1; sAr = 4; sBr = 6; step(403);
    clr(); sAr = 4; sBr = 6; step(404);

    // 5: commit under stall with boost on 2
    clr(); sAv = 1; sAb = 1; sAi = 2; sAr = 2; step(500);
    clr(); sStall = 1; sCmt = 1; sAr = 2; step(501);
    clr(); sCmt = 1; sAr = 2; step(502);
    clr(); sAr = 2; step(503);

    // 6: same-index collision, index-0 write, async reset with boost pending
    clr(); sAv = 1; sAb = 1; sAi = 8; sBv = 1; sBb = 0; sBi = 8; sAr = 8; step(600);
    clr(); sBv = 1; sBb = 1; sBi = 0; sAr = 8; sBr = 0; step(601);
    clr(); sAr = 0; sBr = 8; sAv = 1; sAb = 1; sAi = 10; step(602);
    clr(); sRst = 1; sAr = 10; step(603);
    clr(); sAr = 10; step(604);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      clr();
      sRst   = ($urandom_range(0, 99) == 0);
      sExc   = ($urandom_range(0, 15) == 0);
      sStall = ($urandom_range(0, 5) == 0);
      sCmt   = ($urandom_range(0, 3) == 0);
      sSq    = ($urandom_range(0, 7) == 0);
      sAv    = $urandom_range(0, 1); sAb = $urandom_range(0, 1); sAi = $urandom_range(0, 11);
      sBv    = $urandom_range(0, 1); sBb = $urandom_range(0, 1); sBi = $urandom_range(0, 11);
      sAr    = $urandom_range(0, 11); sBr = $urandom_range(0, 11);
      step(1000 + i);
    end

    clr(); step(9000);
    @(negedge Phi1);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
